// File: rtl/adder_tree_sched_pkg.sv
// Shared constants and helpers for the adder_tree_sched pipeline.
package adder_tree_sched_pkg;

  // Number of operands per request, and the depth of the tree.
  localparam int NUM_OPS      = 8;
  localparam int TREE_LEVELS  = 3;
  localparam int PIPE_LATENCY = 3;
  localparam int STAT_W       = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Id width for the default four-requester build.
  localparam int DEFAULT_ID_W = id_width(4);

endpackage

// File: rtl/adder_tree_branch.sv
// One 2-input node of the adder tree.
// The output is one bit wider than the inputs, so the carry is never lost.
module adder_tree_branch #(
  parameter int ADDER_WIDTH = 32,
  parameter int EXTRA_BITS  = 0
) (
  input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] a,
  input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] b,
  output logic [ADDER_WIDTH+EXTRA_BITS:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_tree_sched_rr_arb.sv
// Round-robin arbiter. Priority starts one past the last grant and wraps.
// The pointer moves only when advance is high (a transfer took place).
module adder_tree_sched_rr_arb
  import adder_tree_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  // Search from ptr+1 upward; NUM_REQ is a power of two, so ID_W-bit
  // truncation provides the wrap from NUM_REQ-1 to 0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ptr + ID_W'(off);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  // Pointer register: reset to the last requester so requester 0 leads.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (advance) begin
      ptr <= grant_id;
    end
  end

endmodule

// File: rtl/adder_tree_sched.sv
// Arbitrated 8-operand adder tree with three register stages.
// Optional statistics counters: define ADDER_TREE_SCHED_STATS_EN.
module adder_tree_sched
  import adder_tree_sched_pkg::*;
#(
  parameter int ADDER_WIDTH = 32,
  parameter int NUM_REQ     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*NUM_OPS*ADDER_WIDTH-1:0] req_data,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [id_width(NUM_REQ)-1:0]        res_id,
  output logic [ADDER_WIDTH+2:0]              res_sum
`ifdef ADDER_TREE_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]           stat_grant_cnt,
  output logic [STAT_W-1:0]                   stat_stall_cnt
`endif
);

  localparam int ID_W = id_width(NUM_REQ);

  logic                   en;
  logic                   xfer;
  logic [NUM_REQ-1:0]     arb_req;
  logic [ID_W-1:0]        grant_id;
  logic [ADDER_WIDTH-1:0] ops [NUM_OPS];

  logic [ADDER_WIDTH:0]   l0_sum [NUM_OPS/2];
  logic [ADDER_WIDTH+1:0] l1_sum [NUM_OPS/4];
  logic [ADDER_WIDTH+2:0] l2_sum;

  logic                   s1_valid, s2_valid, s3_valid;
  logic [ID_W-1:0]        s1_id, s2_id, s3_id;
  logic [ADDER_WIDTH:0]   s1_sum [NUM_OPS/2];
  logic [ADDER_WIDTH+1:0] s2_sum [NUM_OPS/4];
  logic [ADDER_WIDTH+2:0] s3_sum;

  // The whole pipe advances together unless the output is held.
  assign en      = !s3_valid || res_ready;
  assign arb_req = req_valid & {NUM_REQ{en && !rst}};
  assign xfer    = |req_ready;

  adder_tree_sched_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (arb_req),
    .advance  (xfer),
    .grant    (req_ready),
    .grant_id (grant_id)
  );

  // Select the granted requester's eight operands.
  always_comb begin
    for (int j = 0; j < NUM_OPS; j++) begin
      ops[j] = req_data[(int'(grant_id) * NUM_OPS + j) * ADDER_WIDTH +: ADDER_WIDTH];
    end
  end

  for (genvar g = 0; g < NUM_OPS/2; g++) begin : g_l0
    adder_tree_branch #(.ADDER_WIDTH(ADDER_WIDTH), .EXTRA_BITS(0)) u_add (
      .a (ops[2*g]), .b (ops[2*g+1]), .sum (l0_sum[g])
    );
  end

  for (genvar g = 0; g < NUM_OPS/4; g++) begin : g_l1
    adder_tree_branch #(.ADDER_WIDTH(ADDER_WIDTH), .EXTRA_BITS(1)) u_add (
      .a (s1_sum[2*g]), .b (s1_sum[2*g+1]), .sum (l1_sum[g])
    );
  end

  adder_tree_branch #(.ADDER_WIDTH(ADDER_WIDTH), .EXTRA_BITS(2)) u_l2 (
    .a (s2_sum[0]), .b (s2_sum[1]), .sum (l2_sum)
  );

  // Three pipeline stages, each carrying valid, id and partial sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset too, because res_sum must read 0 out of reset.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_id    <= '0;
      s2_id    <= '0;
      s3_id    <= '0;
      for (int i = 0; i < NUM_OPS/2; i++) s1_sum[i] <= '0;
      for (int i = 0; i < NUM_OPS/4; i++) s2_sum[i] <= '0;
      s3_sum   <= '0;
    end else if (en) begin
      s1_valid <= xfer;
      s1_id    <= grant_id;
      for (int i = 0; i < NUM_OPS/2; i++) s1_sum[i] <= l0_sum[i];
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      for (int i = 0; i < NUM_OPS/4; i++) s2_sum[i] <= l1_sum[i];
      s3_valid <= s2_valid;
      s3_id    <= s2_id;
      s3_sum   <= l2_sum;
    end
  end

  assign res_valid = s3_valid;
  assign res_id    = s3_id;
  assign res_sum   = s3_sum;

`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NUM_REQ];
  logic [STAT_W-1:0] stall_cnt;

  // Saturating per-requester transfer counters and output-stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && grant_cnt[i] != '1) begin
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
        end
      end
      if (s3_valid && !res_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  // Flatten the counter array onto the output port.
  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grant_cnt[i*STAT_W +: STAT_W] = grant_cnt[i];
    end
  end

  assign stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed testbench for adder_tree_sched (W=32, four requesters).
// Define ADDER_TREE_SCHED_STATS_EN to also exercise the statistics counters.
module tb_adder_tree_sched;

  localparam int W = 32;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*8*W-1:0]  req_data;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_id;
  logic [W+2:0]      res_sum;
`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [N*16-1:0]   stat_grant_cnt;
  logic [15:0]       stat_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  adder_tree_sched #(.ADDER_WIDTH(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum)
`ifdef ADDER_TREE_SCHED_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int r, input int j, input logic [W-1:0] val);
    req_data[(r*8 + j)*W +: W] = val;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) for a result, check it, then let it be consumed.
  task automatic wait_result(input string tag, input int exp_id, input logic [63:0] exp_sum);
    int k = 0;
    while (!res_valid && k < 8) begin
      next_cycle();
      k++;
    end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_id"}, res_id, exp_id);
    check({tag, "_sum"}, res_sum, exp_sum);
    next_cycle();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    rst       = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    req_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, with every requester asking.
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_res_id", res_id, 0);
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    rst       = 1'b0;

    // Single request from requester 2: operands 1..8, sum 36, latency check.
    for (int j = 0; j < 8; j++) set_op(2, j, W'(j + 1));
    next_cycle();
    req_valid = 4'b0100;
    #1 check("single_ready", req_ready, 4'b0100);
    next_cycle();
    req_valid = '0;
    check("single_lat1", res_valid, 0);
    next_cycle();
    check("single_lat2", res_valid, 0);
    next_cycle();
    check("single_valid", res_valid, 1);
    check("single_sum", res_sum, 36);
    check("single_id", res_id, 2);
    next_cycle();
    check("single_bubble", res_valid, 0);

    // All-ones operands: no carry is lost.
    for (int j = 0; j < 8; j++) set_op(0, j, '1);
    req_valid = 4'b0001;
    #1 check("ovf_ready", req_ready, 4'b0001);
    next_cycle();
    req_valid = '0;
    wait_result("ovf", 0, 64'h7_FFFF_FFF8);

    // Fresh reset so requester 0 leads, then all four requesting.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < 8; j++) set_op(r, j, W'(r*16 + j));
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      #1 check($sformatf("rr_grant%0d", c), req_ready, 64'(1 << (c % 4)));
      if (c >= 3) begin
        check($sformatf("rr_valid%0d", c), res_valid, 1);
        check($sformatf("rr_id%0d", c), res_id, (c - 3) % 4);
        check($sformatf("rr_sum%0d", c), res_sum, 128*((c - 3) % 4) + 28);
      end else begin
        check($sformatf("rr_empty%0d", c), res_valid, 0);
      end
      next_cycle();
    end

    // Stall the output for five cycles with the pipe full.
    res_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1 check($sformatf("stall_ready%0d", s), req_ready, 0);
      check($sformatf("stall_valid%0d", s), res_valid, 1);
      check($sformatf("stall_id%0d", s), res_id, 3);
      check($sformatf("stall_sum%0d", s), res_sum, 412);
      next_cycle();
    end
    res_ready = 1'b1;
    req_valid = '0;
    #1 check("drain0_id", res_id, 3);
    check("drain0_valid", res_valid, 1);
    next_cycle();
    check("drain1_valid", res_valid, 1);
    check("drain1_id", res_id, 0);
    check("drain1_sum", res_sum, 28);
    next_cycle();
    check("drain2_valid", res_valid, 1);
    check("drain2_id", res_id, 1);
    check("drain2_sum", res_sum, 156);
    next_cycle();
    check("drain_done", res_valid, 0);
`ifdef ADDER_TREE_SCHED_STATS_EN
    check("stat_stall", stat_stall_cnt, 5);
    check("stat_grant0", stat_grant_cnt[0 +: 16], 3);
    check("stat_grant1", stat_grant_cnt[16 +: 16], 3);
    check("stat_grant2", stat_grant_cnt[32 +: 16], 2);
    check("stat_grant3", stat_grant_cnt[48 +: 16], 2);
`endif

    // Two results in flight, then reset: none may appear afterwards.
    req_valid = 4'b0110;
    next_cycle();
    next_cycle();
    req_valid = '1;
    rst       = 1'b1;
    #1 check("mid_rst_valid", res_valid, 0);
    check("mid_rst_ready", req_ready, 0);
    next_cycle();
    rst       = 1'b0;
    req_valid = '0;
    stale     = 0;
    for (int c = 0; c < 6; c++) begin
      if (res_valid) stale++;
      next_cycle();
    end
    check("no_stale", stale, 0);
    req_valid = '1;
    #1 check("post_rst_grant", req_ready, 4'b0001);
    next_cycle();
    req_valid = '0;
    wait_result("post_rst", 0, 28);

`ifdef ADDER_TREE_SCHED_STATS_EN
    // Saturation of requester 1's transfer counter.
    req_valid = 4'b0010;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    check("stat_sat1", stat_grant_cnt[16 +: 16], 16'hFFFF);
    check("stat_keep0", stat_grant_cnt[0 +: 16], 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
